// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS) requesters,
// counts out a fixed read latency. Define ARB_ROUND_ROBIN_EN for round-robin contention.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [2:0]        ls_funct3,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_wren,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);

    generate
        if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
            $error("mem_port_arbiter: MEM_LATENCY must be in 1..4");
        end
    endgenerate

    // Handshake: a requester holds req (and its fields) stable until the cycle it sees gnt;
    // gnt is that acceptance. Dropping req before gnt withdraws it. Read data returns on a
    // one-cycle rvalid pulse to the requester that owns the access.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic              ls_wins;
    logic              grant_ls;
    logic              grant_if;

`ifdef ARB_ROUND_ROBIN_EN
    logic              rr_q, rr_d;
    // The pointer names the last winner, so the other requester wins the next tie.
    assign ls_wins = (rr_q == OWN_IF);
`else
    assign ls_wins = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        f3_d        = f3_q;
`ifdef ARB_ROUND_ROBIN_EN
        rr_d        = rr_q;
`endif
        grant_ls    = 1'b0;
        grant_if    = 1'b0;
        if_gnt      = 1'b0;
        ls_gnt      = 1'b0;
        if_rvalid   = 1'b0;
        ls_rvalid   = 1'b0;
        if_rdata    = '0;
        ls_rdata    = '0;
        mem_address = addr_q;
        mem_data_in = '0;
        mem_wren    = 1'b0;
        mem_funct3  = f3_q;
        busy        = 1'b0;

        // Outputs are forced quiet during the reset cycle so nothing is granted or returned.
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    grant_ls = ls_req && (!if_req || ls_wins);
                    grant_if = if_req && !grant_ls;
                    if (grant_ls) begin
                        ls_gnt      = 1'b1;
                        mem_address = ls_addr;
                        mem_data_in = ls_wdata;
                        mem_funct3  = ls_funct3;
                        mem_wren    = ls_we;
                        addr_d      = ls_addr;
                        f3_d        = ls_funct3;
                        owner_d     = OWN_LS;
`ifdef ARB_ROUND_ROBIN_EN
                        rr_d        = OWN_LS;
`endif
                        if (!ls_we) begin
                            state_d = WAIT;
                            cnt_d   = 3'(MEM_LATENCY);
                        end
                    end else if (grant_if) begin
                        if_gnt      = 1'b1;
                        mem_address = if_addr;
                        mem_funct3  = 3'b010;
                        addr_d      = if_addr;
                        f3_d        = 3'b010;
                        owner_d     = OWN_IF;
`ifdef ARB_ROUND_ROBIN_EN
                        rr_d        = OWN_IF;
`endif
                        state_d     = WAIT;
                        cnt_d       = 3'(MEM_LATENCY);
                    end
                end
                WAIT: begin
                    busy  = 1'b1;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                        if (owner_q == OWN_LS) begin
                            ls_rvalid = 1'b1;
                            ls_rdata  = mem_data_out;
                        end else begin
                            if_rvalid = 1'b1;
                            if_rdata  = mem_data_out;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            owner_q <= OWN_IF;
            addr_q  <= '0;
            f3_q    <= 3'b000;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q    <= OWN_IF;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q    <= rr_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, checked every cycle
// against a queue-based reference of outstanding reads stamped with completion cycles.
module tb_mem_port_arbiter;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [2:0]  ls_funct3;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_wren;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_data_out;
    logic        busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_funct3(ls_funct3), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_wren(mem_wren),
        .mem_funct3(mem_funct3), .mem_data_out(mem_data_out), .busy(busy)
    );

    // Memory contents are a fixed function of the address presented.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5a3c_0f96;
    endfunction

    always_comb mem_data_out = mem_fn(mem_address);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          done;
        bit          ls;
        logic [31:0] addr;
        logic [2:0]  f3;
    } rd_t;

    rd_t         exp_q[$];
    int          cyc = 0;
    logic [31:0] last_addr = '0;
    logic [2:0]  last_f3 = '0;
    bit          last_grant_ls = 1'b0;

    task automatic step();
        logic        e_ifg, e_lsg, e_ifv, e_lsv, e_wren, e_busy;
        logic [31:0] e_ifd, e_lsd, e_addr;
        logic [2:0]  e_f3;
        bit          ls_first;
        rd_t         r;
        @(negedge clk);
        e_ifg = 0; e_lsg = 0; e_ifv = 0; e_lsv = 0; e_wren = 0; e_busy = 0;
        e_ifd = '0; e_lsd = '0; e_addr = last_addr; e_f3 = last_f3;
        if (reset) begin
            exp_q.delete();
            last_addr = '0;
            last_f3 = '0;
            last_grant_ls = 1'b0;
        end else if (exp_q.size() != 0) begin
            r = exp_q[0];
            e_busy = 1;
            e_addr = r.addr;
            e_f3 = r.f3;
            if (cyc == r.done) begin
                if (r.ls) begin e_lsv = 1; e_lsd = mem_fn(r.addr); end
                else begin e_ifv = 1; e_ifd = mem_fn(r.addr); end
                void'(exp_q.pop_front());
            end
        end else begin
`ifdef ARB_ROUND_ROBIN_EN
            ls_first = !last_grant_ls;
`else
            ls_first = 1'b1;
`endif
            if (ls_req && (!if_req || ls_first)) begin
                e_lsg = 1; e_addr = ls_addr; e_f3 = ls_funct3; e_wren = ls_we;
                check_eq("ls_wdata_out", 64'(mem_data_in), 64'(ls_wdata));
                last_addr = ls_addr; last_f3 = ls_funct3; last_grant_ls = 1'b1;
                if (!ls_we) exp_q.push_back('{cyc + LAT, 1'b1, ls_addr, ls_funct3});
            end else if (if_req) begin
                e_ifg = 1; e_addr = if_addr; e_f3 = 3'b010;
                check_eq("if_wdata_out", 64'(mem_data_in), 64'd0);
                last_addr = if_addr; last_f3 = 3'b010; last_grant_ls = 1'b0;
                exp_q.push_back('{cyc + LAT, 1'b0, if_addr, 3'b010});
            end
        end
        check_eq("if_gnt", 64'(if_gnt), 64'(e_ifg));
        check_eq("ls_gnt", 64'(ls_gnt), 64'(e_lsg));
        check_eq("if_rvalid", 64'(if_rvalid), 64'(e_ifv));
        check_eq("ls_rvalid", 64'(ls_rvalid), 64'(e_lsv));
        check_eq("if_rdata", 64'(if_rdata), 64'(e_ifd));
        check_eq("ls_rdata", 64'(ls_rdata), 64'(e_lsd));
        check_eq("mem_wren", 64'(mem_wren), 64'(e_wren));
        check_eq("busy", 64'(busy), 64'(e_busy));
        if (!reset) begin
            check_eq("mem_address", 64'(mem_address), 64'(e_addr));
            check_eq("mem_funct3", 64'(mem_funct3), 64'(e_f3));
        end
        cyc++;
        @(posedge clk);
        #1;
        if (e_ifg) if_req = 1'b0;
        if (e_lsg) ls_req = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic req_fetch(input logic [31:0] a);
        if_req = 1'b1;
        if_addr = a;
    endtask

    task automatic req_ls(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3);
        ls_req = 1'b1;
        ls_we = we;
        ls_addr = a;
        ls_wdata = wd;
        ls_funct3 = f3;
    endtask

    initial begin
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_funct3 = '0;
        steps(2);
        reset = 1'b0;
        step();

        // Single fetch.
        req_fetch(32'h0000_1000);
        steps(LAT + 2);

        // Store with a fetch waiting behind it.
        req_ls(1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 3'b010);
        req_fetch(32'h0000_1004);
        steps(LAT + 3);

        // Load and fetch contending.
        req_ls(1'b0, 32'h0000_2000, 32'h0, 3'b010);
        req_fetch(32'h0000_1008);
        steps(2 * LAT + 3);

        // Continuous contention.
        for (int i = 0; i < 24; i++) begin
            if (!if_req) req_fetch($urandom & 32'hffff_fffc);
            if (!ls_req) req_ls(1'(i % 3 == 0), $urandom, $urandom, 3'($urandom_range(0, 5)));
            step();
        end
        if_req = 1'b0; ls_req = 1'b0;
        steps(LAT + 1);

        // Byte-sized load with a fetch raised one cycle into the wait.
        req_ls(1'b0, 32'h0000_2010, 32'h0, 3'b100);
        step();
        req_fetch(32'h0000_100c);
        steps(2 * LAT + 2);

        // Reset one cycle into a read.
        req_fetch(32'h0000_1010);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_fetch(32'h0000_1014);
        steps(LAT + 2);

        // Fetch raised and dropped while the port is busy.
        req_ls(1'b0, 32'h0000_2020, 32'h0, 3'b010);
        step();
        req_fetch(32'h0000_1018);
        step();
        if_req = 1'b0;
        steps(LAT + 1);

        // Random traffic with withdrawals and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (!if_req) begin
                if ($urandom_range(0, 2) == 0) req_fetch($urandom & 32'hffff_fffc);
            end else if ($urandom_range(0, 15) == 0) begin
                if_req = 1'b0;
            end
            if (!ls_req) begin
                if ($urandom_range(0, 2) == 0)
                    req_ls(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)));
            end else if ($urandom_range(0, 15) == 0) begin
                ls_req = 1'b0;
            end
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        if_req = 1'b0;
        ls_req = 1'b0;
        steps(LAT + 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between the instruction-fetch requester and the load/store requester of the multi-cycle RV32I core.
- Sits between the control unit / datapath and the memory module.
- Arbitrates requests, drives the memory's address, data, write-enable and funct3 inputs, and counts out the fixed read latency.
- Returns read data to the requester that owns the access, with a one-cycle valid pulse.

Parameters:
- MEM_LATENCY, 1, cycles from grant to valid read data on mem_data_out; legal range 1..4, anything else is an elaboration error.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous active-high reset.
- if_req  input  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  input  ADDR_W  fetch address (PC).
- if_gnt  output  1  fetch request accepted this cycle.
- if_rvalid  output  1  one-cycle pulse: if_rdata holds the instruction.
- if_rdata  output  DATA_W  instruction word.
- ls_req  input  1  load/store request; held with ls_* fields stable until ls_gnt.
- ls_we  input  1  1 = store, 0 = load.
- ls_addr  input  ADDR_W  data address.
- ls_wdata  input  DATA_W  store data.
- ls_funct3  input  3  access size/sign (RV32I load/store funct3).
- ls_gnt  output  1  load/store request accepted this cycle.
- ls_rvalid  output  1  one-cycle pulse: ls_rdata holds load data.
- ls_rdata  output  DATA_W  load data.
- mem_address  output  ADDR_W  to memory dmem/imem address.
- mem_data_in  output  DATA_W  to memory write data.
- mem_wren  output  1  to memory write enable.
- mem_funct3  output  3  to memory funct3.
- mem_data_out  input  DATA_W  read data from memory.
- busy  output  1  1 while a read is in flight (state WAIT).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, sampled on posedge clk.
- Reset values:
  - state = IDLE, latency counter = 0, owner = IF, rr pointer = IF.
  - Registered address/funct3 = 0.
  - if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_wren and busy all 0.
- States: IDLE and WAIT.
- IDLE, grant decision (combinational):
  - Default priority is LS over IF.
  - At most one gnt per cycle.
  - No request means no gnt, mem_wren = 0, and mem_address/mem_funct3 hold the registered values.
- IDLE, grant cycle T:
  - mem_address, mem_data_in and mem_funct3 come from the granted requester, combinationally.
  - Address and funct3 are registered on posedge, together with owner.
  - IF grants always use mem_funct3 = 3'b010 (word); mem_data_in = 0.
- Store grant:
  - mem_wren = 1 in cycle T only.
  - State stays IDLE; no rvalid.
  - The next grant is allowed at T+1.
- Read grant (fetch or load):
  - State moves to WAIT and counter loads MEM_LATENCY.
  - In WAIT: mem_address/mem_funct3 driven from registers, mem_wren = 0, counter decrements each cycle, busy = 1.
- Read completion:
  - In cycle T+MEM_LATENCY (counter == 1), the owner's rvalid = 1 and its rdata = mem_data_out (combinational pass-through).
  - The next state is IDLE.
  - Read throughput is one per MEM_LATENCY+1 cycles.
- rdata of the non-owner, and any rdata while rvalid = 0, is 0.
- Requests during WAIT are ignored: no gnt, and requesters keep holding.
- Dropping req before gnt withdraws the request; no side effects.
- Reset mid-read: the in-flight read is abandoned, no rvalid is issued, and state returns to IDLE the next cycle.
- Simultaneous if_req and ls_req in IDLE: LS wins by default (see Optional Feature); IF is granted at the next IDLE cycle if still requesting.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - On simultaneous requests, the winner is the requester not equal to the rr pointer.
  - The rr pointer updates to the granted requester on every grant.
  - IF and LS alternate under continuous contention.
- Undefined:
  - Fixed priority LS > IF; the rr pointer does not exist.
  - IF can starve under continuous ls_req; this is acceptable because the core issues LS only between fetches.

Test Plan:
- Fetch, MEM_LATENCY=1: if_req=1, if_addr=0x1000, mem returns 0x00500093 → if_gnt=1 at T, mem_address=0x1000, mem_funct3=3'b010; if_rvalid=1 at T+1 with if_rdata=0x00500093; busy=1 at T+1 only.
- Store: ls_req=1, ls_we=1, ls_addr=0x2004, ls_wdata=0xDEADBEEF, ls_funct3=3'b010 → ls_gnt=1 and mem_wren=1 in one cycle only; no ls_rvalid; a following if_req is granted the very next cycle.
- Contention: if_req and ls_req (load, 0x2000) both high in IDLE:
  - Default → ls_gnt first, ls_rvalid after MEM_LATENCY, if_gnt the cycle after.
  - With ARB_ROUND_ROBIN_EN, after reset (rr = IF) → ls_gnt first, then if_gnt; repeated contention alternates.
- MEM_LATENCY=3, load 0x2010 (funct3=3'b100) → mem_address/mem_funct3 held for 3 cycles; ls_rvalid pulses once in cycle T+3; an if_req raised at T+1 is granted at T+4.
- Reset at T+1 of a MEM_LATENCY=2 read → no rvalid at T+2; all outputs 0; state IDLE; a new if_req is granted right after reset deasserts.
- Withdrawn request: if_req high only during a WAIT cycle → never granted; no memory activity.
